// File: rtl/ks_carry_lookahead32.sv
//==============================================================================
// Module   : ks_carry_lookahead32
// Brief    : Registered 32-bit Kogge-Stone carry-lookahead unit (g, p, carries, sum)
// Revision : 1.0
//==============================================================================
`default_nettype none

module ks_carry_lookahead32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] g,
  output logic [31:0] p,
  output logic [31:0] c,
  output logic [31:0] sum
);

  localparam int WIDTH  = 32;
  localparam int LEVELS = 5;

  // Row k holds group generate/propagate after prefix level k; row 0 is bitwise.
  logic [LEVELS:0][WIDTH-1:0] grp_g;
  logic [LEVELS:0][WIDTH-1:0] grp_p;
  logic [WIDTH-1:0]           carry_nxt;
  logic [WIDTH-1:0]           sum_nxt;

  always_comb begin
    grp_g    = '0;
    grp_p    = '0;
    grp_g[0] = a & b;
    grp_p[0] = a ^ b;
    for (int k = 1; k <= LEVELS; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << (k - 1))) begin
          grp_g[k][i] = grp_g[k-1][i] | (grp_p[k-1][i] & grp_g[k-1][i - (1 << (k - 1))]);
          grp_p[k][i] = grp_p[k-1][i] & grp_p[k-1][i - (1 << (k - 1))];
        end else begin
          grp_g[k][i] = grp_g[k-1][i];
          grp_p[k][i] = grp_p[k-1][i];
        end
      end
    end
  end

  // Carry-in is fixed at 0, so the group generate G[i:0] is the carry out of bit i.
  assign carry_nxt = grp_g[LEVELS];
  assign sum_nxt   = grp_p[0] ^ {carry_nxt[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g   <= '0;
      p   <= '0;
      c   <= '0;
      sum <= '0;
    end else begin
      g   <= grp_g[0];
      p   <= grp_p[0];
      c   <= carry_nxt;
      sum <= sum_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ks_carry_lookahead32.sv
//==============================================================================
// Module   : tb_ks_carry_lookahead32
// Brief    : Self-checking bench for ks_carry_lookahead32 (vectors + random vs model)
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_ks_carry_lookahead32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [31:0] sum;

  int checks;
  int errors;

  ks_carry_lookahead32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .g     (g),
    .p     (p),
    .c     (c),
    .sum   (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [31:0] sum;
    bit          has_gp;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain 33-bit addition; carry into bit i+1 is bit i+1 of (a+b)^a^b.
  function automatic logic [31:0] ref_sum(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] full;
    full = {1'b0, x} + {1'b0, y};
    return full[31:0];
  endfunction

  function automatic logic [31:0] ref_carry(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] full;
    logic [32:0] cin;
    full = {1'b0, x} + {1'b0, y};
    cin  = full ^ {1'b0, x} ^ {1'b0, y};
    return cin[32:1];
  endfunction

  task automatic chk_model(input string tag, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] eg, ep, ec, es;
    eg = x & y;
    ep = x ^ y;
    ec = ref_carry(x, y);
    es = ref_sum(x, y);
    checks++;
    if (g !== eg || p !== ep || c !== ec || sum !== es) begin
      errors++;
      $display("FAIL %s a=%h b=%h actual g=%h p=%h c=%h sum=%h required g=%h p=%h c=%h sum=%h",
               tag, x, y, g, p, c, sum, eg, ep, ec, es);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] corner_a[4];
    logic [31:0] corner_b[4];

    checks = 0;
    errors = 0;

    vecs[0] = '{32'hffffffff, 32'h00000000, 32'h00000000, 32'hffffffff, 32'h00000000, 32'hffffffff, 1'b1};
    vecs[1] = '{32'ha47ba47b, 32'h5c915c91, 32'h04110411, 32'hf8eaf8ea, 32'hfcf3fcf3, 32'h010d010c, 1'b1};
    vecs[2] = '{32'hbcdabcda, 32'h79867986, 32'h0, 32'h0, 32'hf99ef99e, 32'h36613660, 1'b0};
    vecs[3] = '{32'h96579657, 32'h34563456, 32'h0, 32'h0, 32'h34563456, 32'hcaadcaad, 1'b0};

    corner_a = '{32'h00000000, 32'hffffffff, 32'h80000000, 32'hffffffff};
    corner_b = '{32'h00000000, 32'h00000001, 32'h80000000, 32'hffffffff};

    // Reset held with all-ones operands while the clock runs.
    rst_n = 1'b0;
    a     = 32'hffffffff;
    b     = 32'hffffffff;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_g", g, 32'h0);
    chk("reset_p", p, 32'h0);
    chk("reset_c", c, 32'h0);
    chk("reset_sum", sum, 32'h0);

    // Release between edges; first cycle after release is not checked.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, one per cycle back-to-back; inputs change mid-cycle to
    // confirm outputs hold until the next edge.
    for (int i = 0; i < 4; i++) begin
      a = vecs[i].a;
      b = vecs[i].b;
      @(posedge clk);
      #1;
      if (vecs[i].has_gp) begin
        chk($sformatf("vec%0d_g", i), g, vecs[i].g);
        chk($sformatf("vec%0d_p", i), p, vecs[i].p);
      end
      chk($sformatf("vec%0d_c", i), c, vecs[i].c);
      chk($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
      @(negedge clk);
      a = ~vecs[i].a;
      b = vecs[i].a;
      #1;
      chk($sformatf("vec%0d_hold_sum", i), sum, vecs[i].sum);
    end
    @(negedge clk);
    a = vecs[3].a;
    b = vecs[3].b;
    @(posedge clk);
    #1;
    chk("no_carry_out_c31", {31'b0, c[31]}, 32'h0);

    // Corner pairs through the reference model.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = corner_a[i];
      b = corner_b[i];
      @(posedge clk);
      #1;
      chk_model($sformatf("corner%0d", i), corner_a[i], corner_b[i]);
    end

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    @(negedge clk);
    a = 32'hffffffff;
    b = 32'h00000001;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_clear_c", c, 32'h0);
    chk("async_clear_sum", sum, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random pairs, one per cycle.
    for (int n = 0; n < 10000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 7 == 0) rb = ~ra;
      a = ra;
      b = rb;
      @(posedge clk);
      #1;
      chk_model("random", ra, rb);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
